ped_request: RTL and testbench

PED_REQUEST -- requirements
Module: ped_request

---
 rtl/traffic_pkg.sv | 11 +
 rtl/debouncer.sv | 40 ++++
 rtl/ped_request.sv | 69 ++++++
 tb/tb_ped_request.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-controller constants: crosswalk direction encoding and default debounce depth.
package traffic_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE = 4;

    typedef enum logic {
        DIR_NORTH = 1'b0,
        DIR_EAST  = 1'b1
    } dir_e;

endpackage

// File: rtl/debouncer.sv
// One button channel: 2-flop synchronizer, stability counter, debounced level, registered rise pulse.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = traffic_pkg::DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q;
    logic            level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn};
            rise   <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                // Final differing cycle: flip the level now so the counter never reaches past the limit.
                cnt_q   <= '0;
                level_q <= sync_q[1];
                rise    <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ped_request.sv
// Pedestrian request latch for two crosswalks, with tracking of which pending request is older.
module ped_request
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_north,
    input  logic btn_east,
    input  logic served_north,
    input  logic served_east,
    output logic req_north,
    output logic req_east,
    output logic req_first
);

    logic press_north, press_east;
    logic req_north_d, req_east_d;
    dir_e first_d, first_q;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_north (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_north),
        .rise  (press_north)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_east (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_east),
        .rise  (press_east)
    );

    always_comb begin
        // Service beats a coincident press; a press on a pending channel is absorbed.
        req_north_d = served_north ? 1'b0 : (req_north | press_north);
        req_east_d  = served_east  ? 1'b0 : (req_east  | press_east);
        first_d     = first_q;
        if (req_north_d && req_east_d) begin
            // East newly set (alone or together with north) leaves north as the older one.
            if (!req_east) begin
                first_d = DIR_NORTH;
            end else if (!req_north) begin
                first_d = DIR_EAST;
            end
        end else if (req_north_d) begin
            first_d = DIR_NORTH;
        end else if (req_east_d) begin
            first_d = DIR_EAST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_north <= 1'b0;
            req_east  <= 1'b0;
            first_q   <= DIR_NORTH;
        end else begin
            req_north <= req_north_d;
            req_east  <= req_east_d;
            first_q   <= first_d;
        end
    end

    assign req_first = first_q;

endmodule

// File: tb/tb_ped_request.sv
// Directed checks of ped_request with DEBOUNCE_CYCLES = 4; cycle k is the interval after edge k.
module tb_ped_request;

    logic clk = 1'b0;
    logic reset, btn_north, btn_east, served_north, served_east;
    logic req_north, req_east, req_first;

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    ped_request #(.DEBOUNCE_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_north    (btn_north),
        .btn_east     (btn_east),
        .served_north (served_north),
        .served_east  (served_east),
        .req_north    (req_north),
        .req_east     (req_east),
        .req_first    (req_first)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", tag, cyc, obs, exp);
        end
    endtask

    // Advance one edge; outputs are read 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        reset        = 1'b1;
        btn_north    = 1'b0;
        btn_east     = 1'b0;
        served_north = 1'b0;
        served_east  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset        = 1'b1;
        btn_north    = 1'b0;
        btn_east     = 1'b0;
        served_north = 1'b0;
        served_east  = 1'b0;

        // North held from cycle 0: request from cycle 7.
        reset_dut();
        check_eq("rst_req_north", req_north, 1'b0);
        check_eq("rst_req_east", req_east, 1'b0);
        check_eq("rst_req_first", req_first, 1'b0);
        btn_north = 1'b1;
        while (cyc < 20) begin
            step();
            check_eq("north_latency", req_north, cyc >= 7);
        end
        check_eq("north_only_east", req_east, 1'b0);
        check_eq("north_only_first", req_first, 1'b0);

        // East high for 3 cycles only.
        reset_dut();
        btn_east = 1'b1;
        step(); step(); step();
        btn_east = 1'b0;
        while (cyc < 15) begin
            step();
            check_eq("short_pulse", req_east, 1'b0);
        end

        // East bouncing every cycle for 12 cycles.
        reset_dut();
        while (cyc < 12) begin
            btn_east = (cyc % 2 == 0);
            step();
            check_eq("bounce", req_east, 1'b0);
        end
        btn_east = 1'b0;
        while (cyc < 20) begin
            step();
            check_eq("bounce_tail", req_east, 1'b0);
        end

        // East first, north later; serve east at 20.
        reset_dut();
        btn_east = 1'b1;
        while (cyc < 21) begin
            if (cyc == 5) btn_north = 1'b1;
            served_east = (cyc == 20);
            step();
            if (cyc == 7) begin
                check_eq("order_east_set", req_east, 1'b1);
                check_eq("order_first_east", req_first, 1'b1);
            end
            if (cyc == 11) check_eq("order_north_pre", req_north, 1'b0);
            if (cyc == 12) begin
                check_eq("order_north_set", req_north, 1'b1);
                check_eq("order_first_keep", req_first, 1'b1);
            end
        end
        served_east = 1'b0;
        check_eq("serve_east_req", req_east, 1'b0);
        check_eq("serve_east_first", req_first, 1'b0);
        check_eq("serve_east_north", req_north, 1'b1);

        // Only east pending, then served: req_first holds east.
        reset_dut();
        btn_east = 1'b1;
        while (cyc < 7) step();
        check_eq("hold_first_pre", req_first, 1'b1);
        served_east = 1'b1;
        step();
        served_east = 1'b0;
        step();
        check_eq("hold_req_east", req_east, 1'b0);
        check_eq("hold_first", req_first, 1'b1);

        // Both buttons rise together.
        reset_dut();
        btn_north = 1'b1;
        btn_east  = 1'b1;
        while (cyc < 7) begin
            step();
            if (cyc == 6) begin
                check_eq("both_north_pre", req_north, 1'b0);
                check_eq("both_east_pre", req_east, 1'b0);
            end
        end
        check_eq("both_north", req_north, 1'b1);
        check_eq("both_east", req_east, 1'b1);
        check_eq("both_first", req_first, 1'b0);

        // Served in the press-event cycle wins.
        reset_dut();
        btn_north = 1'b1;
        while (cyc < 15) begin
            served_north = (cyc == 6);
            step();
            check_eq("serve_vs_press", req_north, 1'b0);
        end
        served_north = 1'b0;

        // Reset at counter value 3 (cycle 5): re-qualifies from reset release at cycle 6.
        reset_dut();
        btn_north = 1'b1;
        while (cyc < 5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        while (cyc < 14) begin
            check_eq("midreset_req", req_north, cyc >= 13);
            step();
        end
        check_eq("midreset_final", req_north, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d got=running want=finished", cyc);
        $fatal(1);
    end

endmodule
